led_sel_ctrl: RTL and testbench

//  Vending-machine LED mode scheduler. Arbitrates between idle, credit-level,

---
 rtl/seller_led_pkg.sv | 47 ++++
 rtl/led_tick_timer.sv | 45 ++++
 rtl/led_sel_ctrl.sv | 148 ++++++++++++++
 tb/tb_led_sel_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seller_led_pkg.sv
// ----------------------------------------------------------------------------
// seller_led_pkg
//  Shared types and constants for the vending-machine LED mode scheduler.
//  - led_state_e : scheduler state encoding (also exported as debug mode)
//  - SEL_*       : active-low one-hot select words for the LED output mux
//  - CREDIT_MAX  : credit count at which the credit display saturates
//  - credit_sel  : credit count to select-word decode
// ----------------------------------------------------------------------------
package seller_led_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        FLASH  = 2'd2,
        PULSE  = 2'd3
    } led_state_e;

    localparam logic [6:0] SEL_IDLE  = 7'b0111111;
    localparam logic [6:0] SEL_L1    = 7'b1011111;
    localparam logic [6:0] SEL_L2    = 7'b1101111;
    localparam logic [6:0] SEL_L3    = 7'b1110111;
    localparam logic [6:0] SEL_L4    = 7'b1111011;
    localparam logic [6:0] SEL_FLASH = 7'b1111101;
    localparam logic [6:0] SEL_PULSE = 7'b1111110;

    localparam int CREDIT_MAX = 4;

    // Map the credit count onto a level select; everything from CREDIT_MAX
    // upward shares the top level. A zero count maps to the idle select so
    // the function never returns an illegal word.
    function automatic logic [6:0] credit_sel(input logic [2:0] cnt);
        logic [6:0] sel;
        if (cnt >= 3'(CREDIT_MAX)) begin
            sel = SEL_L4;
        end else begin
            case (cnt)
                3'd0:    sel = SEL_IDLE;
                3'd1:    sel = SEL_L1;
                3'd2:    sel = SEL_L2;
                3'd3:    sel = SEL_L3;
                default: sel = SEL_L4;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/led_tick_timer.sv
// ----------------------------------------------------------------------------
// led_tick_timer
//  Loadable down-counter advanced by a tick enable. Saturates at zero.
//  Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset (clears the count)
//   load     in   load load_val this cycle (load beats tick)
//   load_val in   TW-bit reload value
//   tick     in   timebase enable; decrements a nonzero count
//   zero     out  count is zero
//   expire   out  this tick takes the count from one to zero
// ----------------------------------------------------------------------------
module led_tick_timer #(
    parameter int TW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    output logic          zero,
    output logic          expire
);

    logic [TW-1:0] count_r;

    // Count register: load has priority, decrement only while nonzero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {TW{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (tick && (count_r != {TW{1'b0}})) begin
            count_r <= count_r - TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero   = (count_r == {TW{1'b0}});
    // Caller ignores expire on cycles where it asserts load, so load is not
    // folded in here; that keeps expire free of any path back from load.
    assign expire = tick & (count_r == TW'(1));

endmodule

// File: rtl/led_sel_ctrl.sv
// ----------------------------------------------------------------------------
// led_sel_ctrl
//  Vending-machine LED mode scheduler. Arbitrates idle, credit-level,
//  vend-flash and fault-pulse display requests (fault > vend > credit > idle)
//  and drives the active-low one-hot select bus of the LED mux.
//  Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   tick       in   single-cycle timebase enable
//   coin_cnt   in   current credit count 0..7
//   vend_req   in   single-cycle pulse, start/restart the vend flash
//   fault      in   level, machine fault present
//   sel_n      out  registered active-low one-hot mux select
//   mode       out  current state encoding (debug/status)
//   flash_done out  registered single-cycle pulse on normal flash expiry
// ----------------------------------------------------------------------------
module led_sel_ctrl
    import seller_led_pkg::*;
#(
    parameter int FLASH_TICKS = 3000,
    parameter int PULSE_HOLD  = 500,
    parameter int TW          = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [2:0] coin_cnt,
    input  logic       vend_req,
    input  logic       fault,
    output logic [6:0] sel_n,
    output logic [2:0] mode,
    output logic       flash_done
);

    led_state_e    state_r;
    led_state_e    state_s;
    logic [6:0]    sel_n_r;
    logic [6:0]    sel_n_s;
    logic          flash_done_r;
    logic          flash_done_s;
    logic          load_s;
    logic [TW-1:0] load_val_s;
    logic          tmr_zero_s;
    logic          tmr_expire_s;
    led_state_e    credit_state_s;

    led_tick_timer #(
        .TW (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_val (load_val_s),
        .tick     (tick),
        .zero     (tmr_zero_s),
        .expire   (tmr_expire_s)
    );

    // Where a timed mode falls back to, and where IDLE/CREDIT settle.
    always_comb begin
        if (coin_cnt != 3'd0) begin
            credit_state_s = CREDIT;
        end else begin
            credit_state_s = IDLE;
        end
    end

    // Next-state and timer-load logic with fault > vend > credit priority.
    always_comb begin
        state_s      = state_r;
        load_s       = 1'b0;
        load_val_s   = {TW{1'b0}};
        flash_done_s = 1'b0;
        if (fault) begin
            // Held fault keeps reloading, so the hold time counts from release.
            state_s    = PULSE;
            load_s     = 1'b1;
            load_val_s = TW'(PULSE_HOLD);
        end else begin
            case (state_r)
                IDLE, CREDIT: begin
                    if (vend_req) begin
                        state_s    = FLASH;
                        load_s     = 1'b1;
                        load_val_s = TW'(FLASH_TICKS);
                    end else begin
                        state_s = credit_state_s;
                    end
                end
                FLASH: begin
                    if (vend_req) begin
                        // Restart beats a coincident tick; no completion pulse.
                        load_s     = 1'b1;
                        load_val_s = TW'(FLASH_TICKS);
                    end else if (tmr_expire_s) begin
                        state_s      = credit_state_s;
                        flash_done_s = 1'b1;
                    end else if (tmr_zero_s) begin
                        // Unreachable with a legal load; never strand in FLASH.
                        state_s = credit_state_s;
                    end else begin
                        state_s = FLASH;
                    end
                end
                PULSE: begin
                    // vend_req is deliberately dropped here.
                    if (tmr_expire_s || tmr_zero_s) begin
                        state_s = credit_state_s;
                    end else begin
                        state_s = PULSE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Select word for the state being entered; credit level follows coin_cnt.
    always_comb begin
        case (state_s)
            IDLE:    sel_n_s = SEL_IDLE;
            CREDIT:  sel_n_s = credit_sel(coin_cnt);
            FLASH:   sel_n_s = SEL_FLASH;
            PULSE:   sel_n_s = SEL_PULSE;
            default: sel_n_s = SEL_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            sel_n_r      <= SEL_IDLE;
            flash_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            sel_n_r      <= sel_n_s;
            flash_done_r <= flash_done_s;
        end
    end

    assign sel_n      = sel_n_r;
    assign mode       = {1'b0, state_r};
    assign flash_done = flash_done_r;

endmodule

// File: tb/tb_led_sel_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_sel_ctrl
//  Directed bench for led_sel_ctrl with FLASH_TICKS=4, PULSE_HOLD=3.
//  Inputs change 1 time unit after a rising edge; outputs are checked there.
// ----------------------------------------------------------------------------
module tb_led_sel_ctrl;

    localparam logic [6:0] S_IDLE  = 7'b0111111;
    localparam logic [6:0] S_L1    = 7'b1011111;
    localparam logic [6:0] S_L2    = 7'b1101111;
    localparam logic [6:0] S_L3    = 7'b1110111;
    localparam logic [6:0] S_L4    = 7'b1111011;
    localparam logic [6:0] S_FLASH = 7'b1111101;
    localparam logic [6:0] S_PULSE = 7'b1111110;

    localparam logic [2:0] M_IDLE   = 3'd0;
    localparam logic [2:0] M_CREDIT = 3'd1;
    localparam logic [2:0] M_FLASH  = 3'd2;
    localparam logic [2:0] M_PULSE  = 3'd3;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [2:0] coin_cnt;
    logic       vend_req;
    logic       fault;
    logic [6:0] sel_n;
    logic [2:0] mode;
    logic       flash_done;

    int n_checks;
    int n_fails;

    led_sel_ctrl #(
        .FLASH_TICKS (4),
        .PULSE_HOLD  (3),
        .TW          (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .coin_cnt   (coin_cnt),
        .vend_req   (vend_req),
        .fault      (fault),
        .sel_n      (sel_n),
        .mode       (mode),
        .flash_done (flash_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] e_sel,
                       input logic [2:0] e_mode, input logic e_fd);
        n_checks++;
        assert (sel_n === e_sel) else begin
            n_fails++;
            $error("FAIL %s sel_n: observed %b expected %b", tag, sel_n, e_sel);
        end
        n_checks++;
        assert (mode === e_mode) else begin
            n_fails++;
            $error("FAIL %s mode: observed %0d expected %0d", tag, mode, e_mode);
        end
        n_checks++;
        assert (flash_done === e_fd) else begin
            n_fails++;
            $error("FAIL %s flash_done: observed %b expected %b", tag, flash_done, e_fd);
        end
    endtask

    // One tick-enabled cycle, optionally with a vend request.
    task automatic tick_cyc(input logic v);
        tick = 1'b1; vend_req = v;
        cyc();
        tick = 1'b0; vend_req = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0; tick = 1'b0; coin_cnt = 3'd3; vend_req = 1'b0; fault = 1'b0;

        // 1: reset with credit present, then release
        cyc(); cyc();
        chk("reset", S_IDLE, M_IDLE, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk("release_l3", S_L3, M_CREDIT, 1'b0);

        // 2: coin sweep
        coin_cnt = 3'd0; cyc(); chk("coin0", S_IDLE, M_IDLE,   1'b0);
        coin_cnt = 3'd1; cyc(); chk("coin1", S_L1,   M_CREDIT, 1'b0);
        coin_cnt = 3'd2; cyc(); chk("coin2", S_L2,   M_CREDIT, 1'b0);
        coin_cnt = 3'd3; cyc(); chk("coin3", S_L3,   M_CREDIT, 1'b0);
        coin_cnt = 3'd4; cyc(); chk("coin4", S_L4,   M_CREDIT, 1'b0);
        coin_cnt = 3'd5; cyc(); chk("coin5", S_L4,   M_CREDIT, 1'b0);
        coin_cnt = 3'd6; cyc(); chk("coin6", S_L4,   M_CREDIT, 1'b0);
        coin_cnt = 3'd7; cyc(); chk("coin7", S_L4,   M_CREDIT, 1'b0);
        coin_cnt = 3'd0; cyc(); chk("coin_back0", S_IDLE, M_IDLE, 1'b0);

        // 3: plain flash of 4 ticks, coin change ignored inside FLASH
        vend_req = 1'b1; cyc(); vend_req = 1'b0;
        chk("flash_enter", S_FLASH, M_FLASH, 1'b0);
        coin_cnt = 3'd2; cyc();
        chk("flash_coin_ignored", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("flash_t1", S_FLASH, M_FLASH, 1'b0);
        cyc();          chk("flash_gap", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("flash_t2", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("flash_t3", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("flash_t4_exit", S_L2, M_CREDIT, 1'b1);
        cyc();          chk("flash_done_one", S_L2, M_CREDIT, 1'b0);

        // 4: restart after 2 ticks, coincident tick on the reload cycle
        vend_req = 1'b1; cyc(); vend_req = 1'b0;
        chk("rs_enter", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("rs_t1", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("rs_t2", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b1); chk("rs_reload", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("rs_r1", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("rs_r2", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("rs_r3", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("rs_r4_exit", S_L2, M_CREDIT, 1'b1);
        cyc();          chk("rs_after", S_L2, M_CREDIT, 1'b0);

        // 5: fault aborts flash, hold time after release, vend dropped
        vend_req = 1'b1; cyc(); vend_req = 1'b0;
        chk("ab_enter", S_FLASH, M_FLASH, 1'b0);
        tick_cyc(1'b0); chk("ab_t1", S_FLASH, M_FLASH, 1'b0);
        fault = 1'b1; cyc();
        chk("ab_pulse", S_PULSE, M_PULSE, 1'b0);
        tick_cyc(1'b0); chk("ab_hold_t", S_PULSE, M_PULSE, 1'b0);
        tick_cyc(1'b0); chk("ab_hold_t2", S_PULSE, M_PULSE, 1'b0);
        fault = 1'b0; vend_req = 1'b1; cyc(); vend_req = 1'b0;
        chk("ab_vend_drop", S_PULSE, M_PULSE, 1'b0);
        tick_cyc(1'b0); chk("ab_p1", S_PULSE, M_PULSE, 1'b0);
        tick_cyc(1'b0); chk("ab_p2", S_PULSE, M_PULSE, 1'b0);
        tick_cyc(1'b0); chk("ab_p3_exit", S_L2, M_CREDIT, 1'b0);
        cyc();          chk("ab_no_queued_vend", S_L2, M_CREDIT, 1'b0);

        // 6: reset mid-PULSE, then fault+vend together on release
        fault = 1'b1; cyc(); fault = 1'b0;
        chk("rp_pulse", S_PULSE, M_PULSE, 1'b0);
        tick_cyc(1'b0); chk("rp_t1", S_PULSE, M_PULSE, 1'b0);
        rst_n = 1'b0; cyc();
        chk("rp_reset", S_IDLE, M_IDLE, 1'b0);
        fault = 1'b1; vend_req = 1'b1; cyc();
        chk("rp_reset_hold", S_IDLE, M_IDLE, 1'b0);
        rst_n = 1'b1; cyc();
        chk("rp_fault_wins", S_PULSE, M_PULSE, 1'b0);
        fault = 1'b0; vend_req = 1'b0; coin_cnt = 3'd0;
        tick_cyc(1'b0); chk("rp_p1", S_PULSE, M_PULSE, 1'b0);
        tick_cyc(1'b0); chk("rp_p2", S_PULSE, M_PULSE, 1'b0);
        tick_cyc(1'b0); chk("rp_p3_idle", S_IDLE, M_IDLE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
